// File: rtl/mul_ctrl_fsm.sv
// Control FSM for the repeated-addition multiplier: loads A and B from data_in, pulses ldP B times, then pulses done.
// Optional build macro MUL_ZERO_SKIP_EN: when A or B is zero, skip the ADD phase and go straight to DONE.
//
// state | meaning
// IDLE  | waiting for start
// LDA   | data_in holds A; ldA loads the A register
// LDB   | data_in holds B; clrP clears the product, B goes into cnt
// ADD   | ldP while cnt != 0, counting down; leave when cnt == 0
// DONE  | one-cycle done pulse, then back to IDLE

module mul_ctrl_fsm #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic              ldA,
  output logic              clrP,
  output logic              ldP,
  output logic              eqz,
  output logic [WORD_W-1:0] cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDA  = 3'd1,
    ST_LDB  = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] cnt_nxt;
`ifdef MUL_ZERO_SKIP_EN
  logic              a_zero, a_zero_nxt;
`endif

  assign eqz = (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef MUL_ZERO_SKIP_EN
    a_zero_nxt = a_zero;
`endif
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LDA;
      end
      ST_LDA: begin
`ifdef MUL_ZERO_SKIP_EN
        a_zero_nxt = (data_in == '0);
`endif
        state_nxt = ST_LDB;
      end
      ST_LDB: begin
        cnt_nxt = data_in;
`ifdef MUL_ZERO_SKIP_EN
        if (a_zero || (data_in == '0)) state_nxt = ST_DONE;
        else                           state_nxt = ST_ADD;
`else
        state_nxt = ST_ADD;
`endif
      end
      ST_ADD: begin
        // Decrement only while non-zero so the counter can never wrap.
        if (cnt != '0) cnt_nxt   = cnt - 1'b1;
        else           state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ldA   <= 1'b0;
      clrP  <= 1'b0;
      ldP   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MUL_ZERO_SKIP_EN
      a_zero <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ldA   <= (state_nxt == ST_LDA);
      clrP  <= (state_nxt == ST_LDB);
      ldP   <= (state_nxt == ST_ADD) && (cnt_nxt != '0);
      busy  <= (state_nxt == ST_LDA) || (state_nxt == ST_LDB) || (state_nxt == ST_ADD);
      done  <= (state_nxt == ST_DONE);
`ifdef MUL_ZERO_SKIP_EN
      a_zero <= a_zero_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mul_ctrl_fsm.sv
// Directed bench for mul_ctrl_fsm with a small A/P accumulator model driven by the control outputs.
// Expectations follow MUL_ZERO_SKIP_EN when it is defined for the build.

module tb_mul_ctrl_fsm;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] data_in;
  logic         ldA, clrP, ldP, eqz, busy, done;
  logic [W-1:0] cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_ctrl_fsm #(.WORD_W(W)) dut (
    .clk(clk), .clear(clear), .start(start), .data_in(data_in),
    .ldA(ldA), .clrP(clrP), .ldP(ldP), .eqz(eqz), .cnt(cnt),
    .busy(busy), .done(done)
  );

  // Downstream A register and product accumulator
  logic [W-1:0] a_reg;
  logic [31:0]  p_acc;
  always @(posedge clk) begin
    if (ldA) a_reg <= data_in;
    if (clrP)     p_acc <= 32'd0;
    else if (ldP) p_acc <= p_acc + {16'd0, a_reg};
  end

  logic         tr_ldA  [32];
  logic         tr_clrP [32];
  logic         tr_busy [32];
  logic         tr_done [32];
  logic         tr_eqz  [32];
  logic [W-1:0] tr_cnt  [32];
  int done_cyc, done_cnt, ldp_cnt, ldp_first, ldp_last, busy_cnt, lda_cyc, clrp_cyc;

  // Cycle 0 is the IDLE cycle in which start_mask[0] is presented. Outputs sampled mid-cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [31:0] start_mask, input int clear_cyc, input int ncyc);
    done_cyc = -1; done_cnt = 0; ldp_cnt = 0; ldp_first = -1; ldp_last = -1;
    busy_cnt = 0; lda_cyc = -1; clrp_cyc = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      tr_ldA[k] = ldA; tr_clrP[k] = clrP; tr_busy[k] = busy;
      tr_done[k] = done; tr_eqz[k] = eqz; tr_cnt[k] = cnt;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (ldP) begin
        ldp_cnt++;
        if (ldp_first < 0) ldp_first = k;
        ldp_last = k;
      end
      if (busy) busy_cnt++;
      if (ldA && lda_cyc < 0) lda_cyc = k;
      if (clrP && clrp_cyc < 0) clrp_cyc = k;
      start   = start_mask[k];
      clear   = (k == clear_cyc);
      data_in = ldA ? a : (clrP ? b : 16'hDEAD);
    end
    start   = 1'b0;
    clear   = 1'b0;
    data_in = 16'hDEAD;
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b1; data_in = 16'h1234;
    repeat (2) @(negedge clk);
    clear = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if ({ldA, clrP, ldP, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_outs: got %b want 00000", {ldA, clrP, ldP, busy, done});
    end
    checks++; if (eqz !== 1'b1) begin
      errors++; $display("FAIL reset_eqz: got %b want 1", eqz);
    end
    checks++; if (cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", cnt);
    end
    @(negedge clk);
    checks++; if ({ldA, busy, done} !== 3'b0) begin
      errors++; $display("FAIL reset_idle_stays: got %b want 000", {ldA, busy, done});
    end
  endtask

  task automatic test_basic;
    run_op(16'd5, 16'd3, 32'h1, -1, 10);
    checks++; if (lda_cyc !== 1) begin
      errors++; $display("FAIL basic_lda_cyc: got %0d want 1", lda_cyc);
    end
    checks++; if (clrp_cyc !== 2) begin
      errors++; $display("FAIL basic_clrp_cyc: got %0d want 2", clrp_cyc);
    end
    checks++; if (ldp_cnt !== 3 || ldp_first !== 3 || ldp_last !== 5) begin
      errors++; $display("FAIL basic_ldp: got n=%0d first=%0d last=%0d want 3/3/5", ldp_cnt, ldp_first, ldp_last);
    end
    checks++; if (tr_cnt[3] !== 16'd3 || tr_cnt[5] !== 16'd1) begin
      errors++; $display("FAIL basic_cnt: got c3=%0d c5=%0d want 3/1", tr_cnt[3], tr_cnt[5]);
    end
    checks++; if (tr_eqz[6] !== 1'b1 || tr_eqz[4] !== 1'b0) begin
      errors++; $display("FAIL basic_eqz: got e6=%b e4=%b want 1/0", tr_eqz[6], tr_eqz[4]);
    end
    checks++; if (done_cyc !== 7 || done_cnt !== 1) begin
      errors++; $display("FAIL basic_done: got cyc=%0d n=%0d want 7/1", done_cyc, done_cnt);
    end
    checks++; if (busy_cnt !== 6 || tr_busy[7] !== 1'b0) begin
      errors++; $display("FAIL basic_busy: got n=%0d b7=%b want 6/0", busy_cnt, tr_busy[7]);
    end
    checks++; if (p_acc !== 32'd15) begin
      errors++; $display("FAIL basic_product: got %0d want 15", p_acc);
    end
  endtask

  task automatic test_b_zero;
    int exp_done;
`ifdef MUL_ZERO_SKIP_EN
    exp_done = 3;
`else
    exp_done = 4;
`endif
    run_op(16'd7, 16'd0, 32'h1, -1, 8);
    checks++; if (ldp_cnt !== 0) begin
      errors++; $display("FAIL bzero_ldp: got %0d want 0", ldp_cnt);
    end
    checks++; if (done_cyc !== exp_done || done_cnt !== 1) begin
      errors++; $display("FAIL bzero_done: got cyc=%0d n=%0d want %0d/1", done_cyc, done_cnt, exp_done);
    end
    checks++; if (p_acc !== 32'd0) begin
      errors++; $display("FAIL bzero_product: got %0d want 0", p_acc);
    end
  endtask

  task automatic test_a_zero;
    int exp_done, exp_ldp;
`ifdef MUL_ZERO_SKIP_EN
    exp_done = 3; exp_ldp = 0;
`else
    exp_done = 8; exp_ldp = 4;
`endif
    run_op(16'd0, 16'd4, 32'h1, -1, 11);
    checks++; if (ldp_cnt !== exp_ldp) begin
      errors++; $display("FAIL azero_ldp: got %0d want %0d", ldp_cnt, exp_ldp);
    end
    checks++; if (done_cyc !== exp_done) begin
      errors++; $display("FAIL azero_done: got %0d want %0d", done_cyc, exp_done);
    end
    checks++; if (tr_cnt[3] !== 16'd4) begin
      errors++; $display("FAIL azero_cnt_loaded: got %0d want 4", tr_cnt[3]);
    end
    checks++; if (p_acc !== 32'd0) begin
      errors++; $display("FAIL azero_product: got %0d want 0", p_acc);
    end
  endtask

  task automatic test_abort;
    run_op(16'd3, 16'd6, 32'h1, 5, 12);
    checks++; if (done_cnt !== 0) begin
      errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt);
    end
    checks++; if (tr_busy[5] !== 1'b1 || tr_busy[6] !== 1'b0 || tr_cnt[6] !== 16'd0) begin
      errors++; $display("FAIL abort_idle: got b5=%b b6=%b c6=%0d want 1/0/0", tr_busy[5], tr_busy[6], tr_cnt[6]);
    end
    run_op(16'd2, 16'd2, 32'h1, -1, 9);
    checks++; if (done_cyc !== 6 || ldp_cnt !== 2) begin
      errors++; $display("FAIL abort_restart: got done=%0d ldp=%0d want 6/2", done_cyc, ldp_cnt);
    end
    checks++; if (p_acc !== 32'd4) begin
      errors++; $display("FAIL abort_product: got %0d want 4", p_acc);
    end
  endtask

  task automatic test_back_to_back;
    int extra_lda;
    run_op(16'd1, 16'd1, 32'hFFF, -1, 13);
    extra_lda = 0;
    for (int k = 2; k <= 6; k++) if (tr_ldA[k]) extra_lda++;
    checks++; if (done_cyc !== 5) begin
      errors++; $display("FAIL b2b_done: got %0d want 5", done_cyc);
    end
    checks++; if (tr_ldA[1] !== 1'b1 || extra_lda !== 0) begin
      errors++; $display("FAIL b2b_start_ignored: got lda1=%b extra=%0d want 1/0", tr_ldA[1], extra_lda);
    end
    checks++; if (tr_busy[6] !== 1'b0 || tr_ldA[7] !== 1'b1) begin
      errors++; $display("FAIL b2b_relaunch: got b6=%b lda7=%b want 0/1", tr_busy[6], tr_ldA[7]);
    end
    checks++; if (tr_done[11] !== 1'b1 || done_cnt !== 2) begin
      errors++; $display("FAIL b2b_second_done: got d11=%b n=%0d want 1/2", tr_done[11], done_cnt);
    end
    checks++; if (p_acc !== 32'd1) begin
      errors++; $display("FAIL b2b_product: got %0d want 1", p_acc);
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; data_in = 16'hDEAD;
    test_reset();
    test_basic();
    test_b_zero();
    test_a_zero();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
